// File: rtl/mmio_responder.sv
// mmio_responder: I/O window 0x100-0x1FF with LED, synchronised switches, console FIFO, status and cycle counter
// Ports: clk/reset_n (async active-low); mem_cmd/mem_addr/write_data/read_data CPU bus, io_hit steers top-level read mux;
//        sw_in raw switches; halt freezes counter; led_out LED register; tx_data/tx_valid/tx_ready console drain.
module mmio_responder #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] MREAD      = 2'b01,
    parameter logic [1:0] MWRITE     = 2'b10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        io_hit,
    input  logic [7:0]  sw_in,
    input  logic        halt,
    output logic [7:0]  led_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic        rd, wr, a_led, a_sw, a_con, a_st, a_cyc;
    logic [7:0]  sw_meta, sw_sync;
    logic [7:0]  fifo [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    logic        empty, full, pop, push, accept, ovf;
    logic [15:0] cycles;
    logic        unused_wd;
    assign rd        = mem_cmd == MREAD;
    assign wr        = mem_cmd == MWRITE;
    assign a_led     = mem_addr == 9'h100;
    assign a_sw      = mem_addr == 9'h140;
    assign a_con     = mem_addr == 9'h180;
    assign a_st      = mem_addr == 9'h181;
    assign a_cyc     = mem_addr == 9'h182;
    assign io_hit    = (rd | wr) & (a_led | a_sw | a_con | a_st | a_cyc);
    assign read_data = !rd   ? 16'h0000 :
                       a_led ? {8'h00, led_out} :
                       a_sw  ? {8'h00, sw_sync} :
                       a_st  ? {12'h000, ovf, full, empty, halt} :
                       a_cyc ? cycles : 16'h0000;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = wp == rp;
    assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop       = ~empty & tx_ready;
    assign push      = wr & a_con;
    // A push into a full FIFO still lands if the head leaves in the same cycle.
    assign accept    = push & (~full | pop);
    assign tx_valid  = ~empty;
    assign tx_data   = empty ? 8'h00 : fifo[rp[AW-1:0]];
    assign unused_wd = ^write_data[15:8];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
            led_out <= '0;
            wp      <= '0;
            rp      <= '0;
            ovf     <= 1'b0;
            cycles  <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (wr & a_led) led_out <= write_data[7:0];
            if (pop) rp <= rp + 1'b1;
            if (accept) wp <= wp + 1'b1;
            // A dropped byte outranks a clear in the same cycle.
            if (push & ~accept) ovf <= 1'b1;
            else if (wr & a_st & write_data[3]) ovf <= 1'b0;
            if (wr & a_cyc) cycles <= '0;
            else if (!halt) cycles <= cycles + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) fifo[wp[AW-1:0]] <= write_data[7:0];
    end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed and randomized checks of mmio_responder against a queue-based model
module tb_mmio_responder;
    localparam int D = 4;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [1:0]  mem_cmd = 2'b00;
    logic [8:0]  mem_addr = 9'h000;
    logic [15:0] write_data = 16'h0000;
    logic [15:0] read_data;
    logic        io_hit;
    logic [7:0]  sw_in = 8'h00;
    logic        halt = 1'b0;
    logic [7:0]  led_out, tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    int total = 0, bad = 0;
    byte unsigned q[$];
    logic [7:0]  m_led, m_sw1, m_sw2;
    logic        m_ovf;
    logic [15:0] m_cyc;
    always #5 clk = ~clk;
    mmio_responder dut (
        .clk(clk), .reset_n(reset_n), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(read_data), .io_hit(io_hit),
        .sw_in(sw_in), .halt(halt), .led_out(led_out), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );
    function automatic logic mapped(logic [8:0] a);
        return a == 9'h100 || a == 9'h140 || a == 9'h180 || a == 9'h181 || a == 9'h182;
    endfunction
    function automatic logic [15:0] exp_read();
        if (mem_cmd != RD) return 16'h0000;
        case (mem_addr)
            9'h100:  return {8'h00, m_led};
            9'h140:  return {8'h00, m_sw2};
            9'h181:  return {12'h000, m_ovf, q.size() == D, q.size() == 0, halt};
            9'h182:  return m_cyc;
            default: return 16'h0000;
        endcase
    endfunction
    task automatic model_reset();
        q.delete();
        m_led = 8'h00;
        m_sw1 = 8'h00;
        m_sw2 = 8'h00;
        m_ovf = 1'b0;
        m_cyc = 16'h0000;
    endtask
    // Advance the model by one clock using the inputs currently applied, then step past the edge.
    task automatic cycle();
        bit pop, push, keep, w;
        int n;
        n = q.size();
        w = mem_cmd == WR;
        pop = n > 0 && tx_ready;
        push = w && mem_addr == 9'h180;
        keep = n < D || pop;
        if (pop) void'(q.pop_front());
        if (push && keep) q.push_back(write_data[7:0]);
        if (w && mem_addr == 9'h181 && write_data[3]) m_ovf = 1'b0;
        if (push && !keep) m_ovf = 1'b1;
        if (w && mem_addr == 9'h100) m_led = write_data[7:0];
        m_sw2 = m_sw1;
        m_sw1 = sw_in;
        m_cyc = (w && mem_addr == 9'h182) ? 16'h0000 : halt ? m_cyc : m_cyc + 16'd1;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        reset_n = 1'b0;
        mem_cmd = 2'b00;
        halt = 1'b0;
        tx_ready = 1'b0;
        model_reset();
        #3;
        total++; if (led_out !== 8'h00) begin bad++; $display("FAIL reset_led got=%h exp=00", led_out); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        total++; if (io_hit !== 1'b0 || read_data !== 16'h0000) begin bad++; $display("FAIL reset_idle got=%b/%h exp=0/0000", io_hit, read_data); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mem_cmd = RD;
        mem_addr = 9'h100;
        #1;
        total++; if (read_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_led got=%h exp=0000", read_data); end
        mem_addr = 9'h181;
        #1;
        total++; if (read_data !== 16'h0002) begin bad++; $display("FAIL reset_rd_status got=%h exp=0002", read_data); end
        mem_addr = 9'h182;
        #1;
        total++; if (read_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_cycles got=%h exp=0000", read_data); end
        repeat (3) cycle();
        total++; if (read_data !== 16'd3) begin bad++; $display("FAIL reset_count got=%h exp=0003", read_data); end
    endtask
    task automatic test_switches();
        mem_cmd = RD;
        mem_addr = 9'h140;
        sw_in = 8'hA5;
        #1;
        total++; if (read_data !== 16'h0000) begin bad++; $display("FAIL sw_now got=%h exp=0000", read_data); end
        cycle();
        total++; if (read_data !== 16'h0000) begin bad++; $display("FAIL sw_1cyc got=%h exp=0000", read_data); end
        cycle();
        cycle();
        total++; if (read_data !== 16'h00A5) begin bad++; $display("FAIL sw_3cyc got=%h exp=00a5", read_data); end
    endtask
    task automatic test_led();
        mem_cmd = WR;
        mem_addr = 9'h100;
        write_data = 16'h1234;
        #1;
        total++; if (io_hit !== 1'b1) begin bad++; $display("FAIL led_hit got=%b exp=1", io_hit); end
        cycle();
        total++; if (led_out !== 8'h34) begin bad++; $display("FAIL led_out got=%h exp=34", led_out); end
        mem_cmd = RD;
        #1;
        total++; if (read_data !== 16'h0034) begin bad++; $display("FAIL led_read got=%h exp=0034", read_data); end
        mem_cmd = WR;
        mem_addr = 9'h1FF;
        write_data = 16'hFFFF;
        #1;
        total++; if (io_hit !== 1'b0) begin bad++; $display("FAIL unmapped_hit got=%b exp=0", io_hit); end
        cycle();
        total++; if (led_out !== 8'h34) begin bad++; $display("FAIL unmapped_led got=%h exp=34", led_out); end
    endtask
    task automatic test_fifo_overflow();
        tx_ready = 1'b0;
        mem_cmd = WR;
        mem_addr = 9'h180;
        for (int i = 0; i < 5; i++) begin
            write_data = 16'h0041 + 16'(i);
            cycle();
        end
        mem_cmd = RD;
        mem_addr = 9'h181;
        #1;
        total++; if (read_data !== 16'h000C) begin bad++; $display("FAIL ovf_status got=%h exp=000c", read_data); end
        mem_cmd = 2'b00;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== 8'h41 + 8'(i)) begin bad++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'h41 + 8'(i)); end
            cycle();
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
        mem_cmd = WR;
        write_data = 16'h0008;
        cycle();
        mem_cmd = RD;
        #1;
        total++; if (read_data !== 16'h0002) begin bad++; $display("FAIL ovf_clear got=%h exp=0002", read_data); end
    endtask
    task automatic test_full_push_pop();
        logic [7:0] order [4];
        order[0] = 8'h02; order[1] = 8'h03; order[2] = 8'h04; order[3] = 8'h55;
        tx_ready = 1'b0;
        mem_cmd = WR;
        mem_addr = 9'h180;
        for (int i = 1; i <= 4; i++) begin
            write_data = 16'(i);
            cycle();
        end
        write_data = 16'h0055;
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        mem_cmd = RD;
        mem_addr = 9'h181;
        #1;
        total++; if (read_data !== 16'h0004) begin bad++; $display("FAIL fullpp_status got=%h exp=0004", read_data); end
        mem_cmd = 2'b00;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== order[i]) begin bad++; $display("FAIL fullpp_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, order[i]); end
            cycle();
        end
        tx_ready = 1'b0;
    endtask
    task automatic test_counter();
        mem_cmd = WR;
        mem_addr = 9'h182;
        write_data = 16'(($urandom));
        halt = 1'b1;
        cycle();
        mem_cmd = RD;
        repeat (10) cycle();
        total++; if (read_data !== 16'h0000) begin bad++; $display("FAIL cnt_halt got=%h exp=0000", read_data); end
        mem_addr = 9'h181;
        #1;
        total++; if (read_data !== 16'h0003) begin bad++; $display("FAIL cnt_status_halt got=%h exp=0003", read_data); end
        halt = 1'b0;
        mem_addr = 9'h182;
        repeat (5) cycle();
        total++; if (read_data !== 16'd5) begin bad++; $display("FAIL cnt_resume got=%h exp=0005", read_data); end
        mem_cmd = WR;
        cycle();
        mem_cmd = RD;
        #1;
        total++; if (read_data !== 16'h0000) begin bad++; $display("FAIL cnt_write_wins got=%h exp=0000", read_data); end
    endtask
    task automatic test_reset_mid();
        tx_ready = 1'b0;
        mem_cmd = WR;
        mem_addr = 9'h180;
        for (int i = 0; i < 3; i++) begin
            write_data = 16'h0070 + 16'(i);
            cycle();
        end
        mem_cmd = 2'b00;
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL midreset_tx got=%b/%h exp=0/00", tx_valid, tx_data); end
        total++; if (led_out !== 8'h00) begin bad++; $display("FAIL midreset_led got=%h exp=00", led_out); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mem_cmd = RD;
        mem_addr = 9'h181;
        #1;
        total++; if (read_data !== 16'h0002) begin bad++; $display("FAIL midreset_status got=%h exp=0002", read_data); end
    endtask
    task automatic test_random();
        logic [8:0] addrs [6];
        logic [7:0] et;
        addrs[0] = 9'h100; addrs[1] = 9'h140; addrs[2] = 9'h180;
        addrs[3] = 9'h180; addrs[4] = 9'h181; addrs[5] = 9'h182;
        for (int i = 0; i < 400; i++) begin
            mem_cmd = 2'($urandom_range(0, 3));
            mem_addr = ($urandom_range(0, 7) == 0) ? {1'b1, 8'($urandom)} : addrs[$urandom_range(0, 5)];
            write_data = 16'($urandom);
            tx_ready = ($urandom_range(0, 2) != 0);
            halt = ($urandom_range(0, 7) == 0);
            sw_in = 8'($urandom);
            #1;
            et = q.size() != 0 ? q[0] : 8'h00;
            total++; if (read_data !== exp_read()) begin bad++; $display("FAIL rnd_read%0d got=%h exp=%h", i, read_data, exp_read()); end
            total++; if (io_hit !== ((mem_cmd == RD || mem_cmd == WR) && mapped(mem_addr))) begin bad++; $display("FAIL rnd_hit%0d got=%b", i, io_hit); end
            total++; if (tx_valid !== (q.size() != 0) || tx_data !== et) begin bad++; $display("FAIL rnd_tx%0d got=%b/%h exp=%b/%h", i, tx_valid, tx_data, q.size() != 0, et); end
            total++; if (led_out !== m_led) begin bad++; $display("FAIL rnd_led%0d got=%h exp=%h", i, led_out, m_led); end
            cycle();
        end
    endtask
    initial begin
        test_reset();
        test_switches();
        test_led();
        test_fifo_overflow();
        test_full_push_pop();
        test_counter();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
